// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: run controller for the ADC trigger/capture core (arm, count bursts, hold-off, stop).
// Latency: every output is registered and reflects the causing input one clock edge later.
// Backpressure: none; the ADC stream handshake is only observed, never stalled.
// Optional feature: define ADC_SEQ_TIMEOUT_EN to build the ARMED timeout (otherwise o_timed_out is tied 0).
// Ports: i_aclk/i_areset (sync, active-high); i_start/i_abort run control; i_burst_count, i_holdoff_cycles,
//        i_timeout_cycles run config (sampled on accepted start); i_adc_tvalid/i_adc_tlast observed stream;
//        o_nreset_trigger/o_nreset_max_sum to the core; o_busy/o_done/o_timed_out/o_aborted status;
//        o_bursts_done/o_words_seen run counters; o_state (IDLE=0 CLEAR=1 ARMED=2 CAPTURE=3 HOLDOFF=4 DONE=5).
module adc_capture_sequencer #(
   parameter int CLEAR_CYCLES = 2,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 i_aclk,
   input  logic                 i_areset,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [15:0]          i_burst_count,
   input  logic [CNT_WIDTH-1:0] i_holdoff_cycles,
   input  logic [CNT_WIDTH-1:0] i_timeout_cycles,
   input  logic                 i_adc_tvalid,
   input  logic                 i_adc_tlast,
   output logic                 o_nreset_trigger,
   output logic                 o_nreset_max_sum,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_timed_out,
   output logic                 o_aborted,
   output logic [15:0]          o_bursts_done,
   output logic [CNT_WIDTH-1:0] o_words_seen,
   output logic [2:0]           o_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_ARMED   = 3'd2,
      S_CAPTURE = 3'd3,
      S_HOLDOFF = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_next;
   // One phase counter shared by CLEAR, ARMED (timeout) and HOLDOFF; cleared on every state change.
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_holdoff;
   logic [15:0]          r_burst_count;
   logic [15:0]          r_bursts_done;
   logic [CNT_WIDTH-1:0] r_words;
   logic                 r_nrst_trig;
   logic                 r_nrst_max;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_aborted;

   logic w_busy_st;
   logic w_accept;
   logic w_beat;
   logic w_burst_end;
   logic w_last_burst;
   logic w_clear_end;
   logic w_holdoff_end;
   logic w_timeout;

   assign w_busy_st     = (r_state == S_CLEAR) || (r_state == S_ARMED) ||
                          (r_state == S_CAPTURE) || (r_state == S_HOLDOFF);
   // Abort outranks start even when there is no run to abort.
   assign w_accept      = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start && !i_abort;
   assign w_beat        = ((r_state == S_ARMED) || (r_state == S_CAPTURE) || (r_state == S_HOLDOFF)) &&
                          i_adc_tvalid && !i_abort;
   // A tvalid&tlast beat in ARMED is a complete single-beat packet.
   assign w_burst_end   = ((r_state == S_ARMED) || (r_state == S_CAPTURE)) &&
                          i_adc_tvalid && i_adc_tlast && !i_abort;
   assign w_last_burst  = (r_burst_count != 16'd0) && ((r_bursts_done + 16'd1) == r_burst_count);
   assign w_clear_end   = (r_cnt == CNT_WIDTH'(CLEAR_CYCLES - 1));
   assign w_holdoff_end = (r_cnt == (r_holdoff - CNT_WIDTH'(1)));

`ifdef ADC_SEQ_TIMEOUT_EN
   logic [CNT_WIDTH-1:0] r_timeout;
   logic                 r_timed_out;
   // ARMED lasts exactly r_timeout cycles before giving up.
   assign w_timeout   = (r_state == S_ARMED) && (r_timeout != '0) &&
                        (r_cnt == (r_timeout - CNT_WIDTH'(1)));
   assign o_timed_out = r_timed_out;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^i_timeout_cycles;
   assign w_timeout        = 1'b0;
   assign o_timed_out      = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            if (i_abort)          w_next = S_DONE;
            else if (w_clear_end) w_next = S_ARMED;
         end
         S_ARMED: begin
            if (i_abort)               w_next = S_DONE;
            else if (w_burst_end)      w_next = w_last_burst ? S_DONE : S_HOLDOFF;
            else if (i_adc_tvalid)     w_next = S_CAPTURE;
            else if (w_timeout)        w_next = S_DONE;
         end
         S_CAPTURE: begin
            if (i_abort)          w_next = S_DONE;
            else if (w_burst_end) w_next = w_last_burst ? S_DONE : S_HOLDOFF;
         end
         S_HOLDOFF: begin
            if (i_abort)            w_next = S_DONE;
            else if (w_holdoff_end) w_next = S_ARMED;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_aclk) begin
      if (i_areset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_holdoff     <= CNT_WIDTH'(1);
         r_burst_count <= '0;
         r_bursts_done <= '0;
         r_words       <= '0;
         r_nrst_trig   <= 1'b0;
         r_nrst_max    <= 1'b1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
         r_timeout     <= '0;
         r_timed_out   <= 1'b0;
`endif
      end else begin
         r_state     <= w_next;
         // Outputs are decoded from the next state so they line up with r_state.
         r_nrst_trig <= (w_next == S_ARMED) || (w_next == S_CAPTURE);
         r_nrst_max  <= (w_next != S_CLEAR);
         r_busy      <= (w_next == S_CLEAR) || (w_next == S_ARMED) ||
                        (w_next == S_CAPTURE) || (w_next == S_HOLDOFF);
         r_done      <= (w_next == S_DONE);

         if (w_next != r_state) r_cnt <= '0;
         else if (w_busy_st)    r_cnt <= r_cnt + CNT_WIDTH'(1);

         if (w_accept) begin
            r_burst_count <= i_burst_count;
            r_holdoff     <= (i_holdoff_cycles == '0) ? CNT_WIDTH'(1) : i_holdoff_cycles;
            r_bursts_done <= '0;
            r_words       <= '0;
            r_aborted     <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            r_timeout     <= i_timeout_cycles;
            r_timed_out   <= 1'b0;
`endif
         end else begin
            if (w_beat && (r_words != '1)) r_words <= r_words + CNT_WIDTH'(1);
            if (w_burst_end)               r_bursts_done <= r_bursts_done + 16'd1;
            if (w_busy_st && i_abort)      r_aborted <= 1'b1;
`ifdef ADC_SEQ_TIMEOUT_EN
            if (w_timeout && !i_adc_tvalid && !i_abort) r_timed_out <= 1'b1;
`endif
         end
      end
   end

   assign o_nreset_trigger = r_nrst_trig;
   assign o_nreset_max_sum = r_nrst_max;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_aborted        = r_aborted;
   assign o_bursts_done    = r_bursts_done;
   assign o_words_seen     = r_words;
   assign o_state          = r_state;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer: scenario tasks with inline checks against spec-level timing expectations.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the following edge.
// Backpressure: not applicable; the bench plays the ADC stream and run-control master.
module tb_adc_capture_sequencer;
   localparam int CW  = 32;
   localparam int CLR = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort;
   logic [15:0]   burst_count;
   logic [CW-1:0] holdoff_cycles, timeout_cycles;
   logic          tvalid, tlast;
   logic          nrst_trig, nrst_max, busy, done, timed_out, aborted;
   logic [15:0]   bursts_done;
   logic [CW-1:0] words_seen;
   logic [2:0]    state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   adc_capture_sequencer #(.CLEAR_CYCLES(CLR), .CNT_WIDTH(CW)) dut (
      .i_aclk(clk), .i_areset(rst), .i_start(start), .i_abort(abort),
      .i_burst_count(burst_count), .i_holdoff_cycles(holdoff_cycles),
      .i_timeout_cycles(timeout_cycles), .i_adc_tvalid(tvalid), .i_adc_tlast(tlast),
      .o_nreset_trigger(nrst_trig), .o_nreset_max_sum(nrst_max), .o_busy(busy),
      .o_done(done), .o_timed_out(timed_out), .o_aborted(aborted),
      .o_bursts_done(bursts_done), .o_words_seen(words_seen), .o_state(state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; tvalid = 1'b1; tlast = 1'b1;
      tick(); tick();
      start = 1'b0; tvalid = 1'b0; tlast = 1'b0;
      n_cmp++;
      if (state !== 3'd0 || nrst_trig !== 1'b0 || nrst_max !== 1'b1) begin
         n_bad++; $display("FAIL reset_state: state=%0d trig=%b max=%b required 0/0/1", state, nrst_trig, nrst_max);
      end
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0 || aborted !== 1'b0) begin
         n_bad++; $display("FAIL reset_flags: busy=%b done=%b to=%b ab=%b required all 0", busy, done, timed_out, aborted);
      end
      n_cmp++;
      if (bursts_done !== 16'd0 || words_seen !== '0) begin
         n_bad++; $display("FAIL reset_counters: bursts=%0d words=%0d required 0/0", bursts_done, words_seen);
      end
      rst = 1'b0;
   endtask

   // Start timing plus a single-beat packet that finishes a one-burst run.
   task automatic test_start_timing();
      repeat (9) tick();
      n_cmp++;
      if (state !== 3'd0) begin n_bad++; $display("FAIL idle_wait: state=%0d required 0", state); end
      burst_count = 16'd1; holdoff_cycles = 4; timeout_cycles = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 1; i <= CLR; i++) begin
         n_cmp++;
         if (state !== 3'd1 || nrst_trig !== 1'b0 || nrst_max !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL clear_cycle%0d: state=%0d trig=%b max=%b busy=%b required 1/0/0/1", i, state, nrst_trig, nrst_max, busy);
         end
         if (i < CLR) tick();
      end
      tick();
      n_cmp++;
      if (state !== 3'd2 || nrst_trig !== 1'b1 || nrst_max !== 1'b1) begin
         n_bad++; $display("FAIL armed_entry: state=%0d trig=%b max=%b required 2/1/1", state, nrst_trig, nrst_max);
      end
      tvalid = 1'b1; tlast = 1'b1; tick(); tvalid = 1'b0; tlast = 1'b0;
      n_cmp++;
      if (state !== 3'd5 || done !== 1'b1 || busy !== 1'b0 || nrst_trig !== 1'b0 ||
          bursts_done !== 16'd1 || words_seen !== 1) begin
         n_bad++; $display("FAIL single_beat: state=%0d done=%b trig=%b bursts=%0d words=%0d required 5/1/0/1/1", state, done, nrst_trig, bursts_done, words_seen);
      end
   endtask

   // Random runs: random packet lengths, gaps, idle in ARMED and stray beats during hold-off.
   task automatic test_bursts(input int runs);
      int bc, h, heff, words, bursts, e_st, len, nidle;
      for (int r = 0; r < runs; r++) begin
         bc = $urandom_range(1, 4); h = $urandom_range(0, 6); heff = (h == 0) ? 1 : h;
         if (r == 0) begin bc = 3; h = 5; heff = 5; end
         words = 0; bursts = 0; e_st = 2;
         burst_count = 16'(bc); holdoff_cycles = CW'(h); timeout_cycles = 0;
         start = 1'b1; tick(); start = 1'b0;
         // Config inputs changing mid-run must not affect this run.
         burst_count = 16'($urandom_range(1, 9)); holdoff_cycles = CW'($urandom_range(0, 9));
         n_cmp++;
         if (state !== 3'd1 || words_seen !== '0 || bursts_done !== 16'd0 || aborted !== 1'b0) begin
            n_bad++; $display("FAIL run%0d_restart: state=%0d words=%0d bursts=%0d ab=%b required 1/0/0/0", r, state, words_seen, bursts_done, aborted);
         end
         repeat (CLR) tick();
         while (bursts < bc) begin
            nidle = $urandom_range(0, 3);
            for (int k = 0; k <= nidle; k++) begin
               if (k > 0) tick();
               n_cmp++;
               if (state !== 3'd2 || nrst_trig !== 1'b1) begin
                  n_bad++; $display("FAIL run%0d_armed: state=%0d trig=%b required 2/1", r, state, nrst_trig);
               end
            end
            len = (r == 0) ? 4 : $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
               if (b > 0) begin
                  repeat ($urandom_range(0, 2)) begin
                     tick();
                     n_cmp++;
                     if (state !== 3'd3 || nrst_trig !== 1'b1 || words_seen !== CW'(words)) begin
                        n_bad++; $display("FAIL run%0d_gap: state=%0d trig=%b words=%0d required 3/1/%0d", r, state, nrst_trig, words_seen, words);
                     end
                  end
               end
               tvalid = 1'b1; tlast = (b == len - 1); tick(); tvalid = 1'b0; tlast = 1'b0;
               words++;
               if (b == len - 1) begin bursts++; e_st = (bursts == bc) ? 5 : 4; end
               else e_st = 3;
               n_cmp++;
               if (state !== 3'(e_st) || words_seen !== CW'(words) || bursts_done !== 16'(bursts)) begin
                  n_bad++; $display("FAIL run%0d_beat: state=%0d words=%0d bursts=%0d required %0d/%0d/%0d", r, state, words_seen, bursts_done, e_st, words, bursts);
               end
            end
            if (bursts < bc) begin
               for (int i = 1; i <= heff; i++) begin
                  tvalid = 1'($urandom_range(0, 1)); tlast = 1'($urandom_range(0, 1));
                  if (tvalid) words++;
                  tick(); tvalid = 1'b0; tlast = 1'b0;
                  e_st = (i < heff) ? 4 : 2;
                  n_cmp++;
                  if (state !== 3'(e_st) || nrst_trig !== (e_st == 2) || words_seen !== CW'(words)) begin
                     n_bad++; $display("FAIL run%0d_holdoff%0d: state=%0d trig=%b words=%0d required %0d/%b/%0d", r, i, state, nrst_trig, words_seen, e_st, (e_st == 2), words);
                  end
               end
            end
         end
         n_cmp++;
         if (done !== 1'b1 || busy !== 1'b0 || nrst_trig !== 1'b0 || bursts_done !== 16'(bc) || words_seen !== CW'(words)) begin
            n_bad++; $display("FAIL run%0d_end: done=%b busy=%b trig=%b bursts=%0d words=%0d required 1/0/0/%0d/%0d", r, done, busy, nrst_trig, bursts_done, words_seen, bc, words);
         end
      end
   endtask

   task automatic test_holdoff_zero();
      burst_count = 16'd2; holdoff_cycles = 0; timeout_cycles = 0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (CLR) tick();
      tvalid = 1'b1; tlast = 1'b1; tick(); tvalid = 1'b0; tlast = 1'b0;
      n_cmp++;
      if (state !== 3'd4 || nrst_trig !== 1'b0) begin
         n_bad++; $display("FAIL hz_holdoff: state=%0d trig=%b required 4/0", state, nrst_trig);
      end
      tick();
      n_cmp++;
      if (state !== 3'd2 || nrst_trig !== 1'b1) begin
         n_bad++; $display("FAIL hz_rearm: state=%0d trig=%b required 2/1", state, nrst_trig);
      end
      tvalid = 1'b1; tlast = 1'b1; tick(); tvalid = 1'b0; tlast = 1'b0;
      n_cmp++;
      if (state !== 3'd5 || bursts_done !== 16'd2 || words_seen !== 2) begin
         n_bad++; $display("FAIL hz_done: state=%0d bursts=%0d words=%0d required 5/2/2", state, bursts_done, words_seen);
      end
   endtask

   task automatic test_timeout();
      burst_count = 16'd0; holdoff_cycles = 1; timeout_cycles = 20;
      start = 1'b1; tick(); start = 1'b0;
      repeat (CLR) tick();
`ifdef ADC_SEQ_TIMEOUT_EN
      for (int i = 1; i < 20; i++) begin
         tick();
         n_cmp++;
         if (state !== 3'd2) begin n_bad++; $display("FAIL to_wait%0d: state=%0d required 2", i, state); end
      end
      tick();
      n_cmp++;
      if (state !== 3'd5 || timed_out !== 1'b1 || bursts_done !== 16'd0 || done !== 1'b1 || aborted !== 1'b0) begin
         n_bad++; $display("FAIL to_fire: state=%0d to=%b bursts=%0d done=%b ab=%b required 5/1/0/1/0", state, timed_out, bursts_done, done, aborted);
      end
`else
      repeat (1000) tick();
      n_cmp++;
      if (state !== 3'd2 || timed_out !== 1'b0 || nrst_trig !== 1'b1) begin
         n_bad++; $display("FAIL to_disabled: state=%0d to=%b trig=%b required 2/0/1", state, timed_out, nrst_trig);
      end
      abort = 1'b1; tick(); abort = 1'b0;
      n_cmp++;
      if (state !== 3'd5 || aborted !== 1'b1) begin
         n_bad++; $display("FAIL to_abort: state=%0d ab=%b required 5/1", state, aborted);
      end
`endif
   endtask

   task automatic test_abort();
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0; tick();
      n_cmp++;
      if (state !== 3'd0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL start_abort_idle: state=%0d busy=%b required 0/0", state, busy);
      end
      burst_count = 16'd0; holdoff_cycles = 3; timeout_cycles = 0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (CLR) tick();
      tvalid = 1'b1; tick(); tick(); tvalid = 1'b0;
      n_cmp++;
      if (state !== 3'd3) begin n_bad++; $display("FAIL abort_capture: state=%0d required 3", state); end
      abort = 1'b1; tick(); abort = 1'b0;
      n_cmp++;
      if (state !== 3'd5 || aborted !== 1'b1 || nrst_trig !== 1'b0 || done !== 1'b1 || words_seen !== 2 || bursts_done !== 16'd0) begin
         n_bad++; $display("FAIL abort_done: state=%0d ab=%b trig=%b done=%b words=%0d bursts=%0d required 5/1/0/1/2/0", state, aborted, nrst_trig, done, words_seen, bursts_done);
      end
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      n_cmp++;
      if (state !== 3'd5 || aborted !== 1'b1 || words_seen !== 2) begin
         n_bad++; $display("FAIL start_abort_done: state=%0d ab=%b words=%0d required 5/1/2", state, aborted, words_seen);
      end
   endtask

   task automatic test_start_in_holdoff_and_reset();
      burst_count = 16'd2; holdoff_cycles = 8; timeout_cycles = 0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (CLR) tick();
      tvalid = 1'b1; tick(); tlast = 1'b1; tick(); tvalid = 1'b0; tlast = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         start = (i == 3); tick(); start = 1'b0;
         n_cmp++;
         if (state !== ((i < 8) ? 3'd4 : 3'd2) || words_seen !== 2 || bursts_done !== 16'd1) begin
            n_bad++; $display("FAIL start_holdoff%0d: state=%0d words=%0d bursts=%0d required %0d/2/1", i, state, words_seen, bursts_done, (i < 8) ? 4 : 2);
         end
      end
      tvalid = 1'b1; tick(); tvalid = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      n_cmp++;
      if (state !== 3'd0 || nrst_trig !== 1'b0 || nrst_max !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
          aborted !== 1'b0 || timed_out !== 1'b0 || words_seen !== '0 || bursts_done !== 16'd0) begin
         n_bad++; $display("FAIL reset_midrun: state=%0d trig=%b max=%b busy=%b done=%b words=%0d bursts=%0d required reset values", state, nrst_trig, nrst_max, busy, done, words_seen, bursts_done);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; tvalid = 1'b0; tlast = 1'b0;
      burst_count = '0; holdoff_cycles = '0; timeout_cycles = '0;
      test_reset();
      test_start_timing();
      test_bursts(6);
      test_holdoff_zero();
      test_timeout();
      test_abort();
      test_start_in_holdoff_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Run controller for the ADC trigger/capture core. Arms the core's trigger, counts completed AXI-Stream packets (bursts), inserts a hold-off between bursts and ends the run after a programmed burst count, an abort, or an arm timeout. Drives the core's `nreset_trigger` and `nreset_max_sum` inputs. It only observes the core's stream handshake and does not touch the data.

## Interface
- `CLEAR_CYCLES`, 2: cycles `nreset_trigger`/`nreset_max_sum` are held low at run start (≥1).
- `CNT_WIDTH`, 32: width of hold-off, timeout and word counters.
- `aclk` in 1: system clock; all logic on rising edge.
- `areset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle run request; honoured in IDLE/DONE only.
- `abort` in 1: terminates any run; priority over `start`.
- `burst_count` in 16: bursts per run; 0 = unlimited until abort.
- `holdoff_cycles` in CNT_WIDTH: trigger-disabled cycles between bursts; 0 treated as 1.
- `timeout_cycles` in CNT_WIDTH: max cycles in ARMED; 0 = no timeout.
- `adc_tvalid` in 1: core `m_axis_tvalid` (observed).
- `adc_tlast` in 1: core `m_axis_tlast` (observed).
- `nreset_trigger` out 1: to core; low = trigger held in reset.
- `nreset_max_sum` out 1: to core; low = max tracker cleared.
- `busy` out 1: high in CLEAR/ARMED/CAPTURE/HOLDOFF.
- `done` out 1: high in DONE.
- `timed_out` out 1: sticky; run ended by timeout.
- `aborted` out 1: sticky; run ended by abort.
- `bursts_done` out 16: bursts completed this run.
- `words_seen` out CNT_WIDTH: `adc_tvalid` beats this run, saturating.
- `state` out 3: IDLE=0, CLEAR=1, ARMED=2, CAPTURE=3, HOLDOFF=4, DONE=5.

## Operation
- IDLE: `nreset_trigger`=0, `nreset_max_sum`=1. On `start`: clear `bursts_done`, `words_seen`, `timed_out`, `aborted`, then go to CLEAR.
- CLEAR: both nreset outputs low for exactly CLEAR_CYCLES cycles, then ARMED.
- ARMED: `nreset_trigger`=1. The timeout counter starts from 0 on every entry. When `adc_tvalid`=1, count the word and go to CAPTURE; if that beat also has `adc_tlast`=1, treat it as a CAPTURE tlast beat in the same cycle. If the timeout is enabled, `timeout_cycles`≠0 and the counter reaches `timeout_cycles` with no tvalid, set `timed_out` and go to DONE.
- CAPTURE: `nreset_trigger`=1. Each `adc_tvalid` beat increments `words_seen`, which saturates at all-ones. On a `adc_tvalid & adc_tlast` beat, increment `bursts_done` (wraps at 16 bits). If `burst_count`≠0 and the new value equals `burst_count`, go to DONE; otherwise go to HOLDOFF. A gap in tvalid without tlast stays in CAPTURE.
- HOLDOFF: `nreset_trigger`=0 for max(`holdoff_cycles`,1) cycles, then ARMED. `adc_tvalid` beats seen here are counted but do not change state.
- DONE: `nreset_trigger`=0; status outputs held. On `start`, clear counters and flags, then go to CLEAR.
- `abort` in any busy state: go to DONE next cycle, set `aborted`. `abort` in IDLE/DONE: ignored, and `start` in the same cycle is also ignored.
- `start` while busy: ignored.
- `burst_count`, `holdoff_cycles` and `timeout_cycles` are sampled into registers on accepted `start`; later changes affect only the next run.

## Timing
- All outputs are registered; `state` and the nreset outputs change on the edge after the causing input.
- `start` at edge t: `state`=CLEAR and `nreset_trigger`=`nreset_max_sum`=0 from t+1 to t+CLEAR_CYCLES; ARMED from t+CLEAR_CYCLES+1.
- tlast beat at edge t with more bursts due: HOLDOFF from t+1; `nreset_trigger` low for H cycles; ARMED at t+1+H.
- Counter updates (`words_seen`, `bursts_done`) are visible one cycle after the beat.
- Reset values: `state`=IDLE, `nreset_trigger`=0, `nreset_max_sum`=1, `busy`=0, `done`=0, flags=0, counters=0.
- `areset` mid-run forces IDLE next edge and drives `nreset_trigger` low.

## Configuration
- `ADC_SEQ_TIMEOUT_EN` defined: ARMED timeout logic is present as described.
- `ADC_SEQ_TIMEOUT_EN` undefined: timeout counter is not built, `timeout_cycles` is ignored, `timed_out` is tied 0, and ARMED waits indefinitely.

## Test plan
- Reset, CLEAR_CYCLES=2, `start` at cycle 10 -> `state`=1 at cycles 11–12 with both nreset outputs 0; `state`=2 and `nreset_trigger`=1 at cycle 13.
- `burst_count`=3, `holdoff_cycles`=5, three 4-beat packets with tlast on the 4th beat -> `bursts_done`=3, `words_seen`=12, each HOLDOFF holds `nreset_trigger`=0 for 5 cycles, `done`=1 after the 3rd tlast.
- Macro defined, `timeout_cycles`=20, no tvalid -> DONE 20 cycles after ARMED entry, `timed_out`=1, `bursts_done`=0. Macro undefined -> still ARMED after 1000 cycles.
- `burst_count`=0, `abort` raised in CAPTURE mid-packet -> DONE next cycle, `aborted`=1, `nreset_trigger`=0. `start` and `abort` together in IDLE -> stays IDLE.
- `start` pulse during HOLDOFF -> ignored (no restart, counters kept). `areset` in CAPTURE -> IDLE, all outputs at reset values.
- `holdoff_cycles`=0 -> HOLDOFF lasts exactly 1 cycle. Single-beat packet (tvalid & tlast in ARMED) -> counted as one word and one burst.
